// File: rtl/sparc_window_decoder_if.sv
// Register-select decoder bus: decode request, window control and results.
// master = instruction-decode side, slave = the decoder itself.
interface sparc_window_decoder_if #(
    parameter int NWINDOWS = 4,
    parameter int CW       = (NWINDOWS <= 2) ? 1 : $clog2(NWINDOWS),
    parameter int NPHYS    = 8 + 16 * NWINDOWS
);
    logic                Ld;
    logic [4:0]          RegIn;
    logic                Save;
    logic                Restore;
    logic                WrCwp;
    logic [CW-1:0]       CwpIn;
    logic                LdWim;
    logic [NWINDOWS-1:0] WimIn;
    logic [NPHYS-1:0]    Sel;
    logic                SelValid;
    logic [CW-1:0]       Cwp;
    logic [NWINDOWS-1:0] Wim;
    logic                OvfTrap;
    logic                UnfTrap;
    logic                IllegalOp;

    modport master (
        output Ld, RegIn, Save, Restore, WrCwp, CwpIn, LdWim, WimIn,
        input  Sel, SelValid, Cwp, Wim, OvfTrap, UnfTrap, IllegalOp
    );

    modport slave (
        input  Ld, RegIn, Save, Restore, WrCwp, CwpIn, LdWim, WimIn,
        output Sel, SelValid, Cwp, Wim, OvfTrap, UnfTrap, IllegalOp
    );
endinterface

// File: rtl/sparc_window_decoder.sv
// SPARC windowed register-file select decoder.
// Maps a logical register r0..r31 relative to the current window pointer onto
// a registered one-hot physical select, and owns CWP, WIM and window traps.
module sparc_window_decoder #(
    parameter int NWINDOWS = 4,
    parameter int R0_ZERO  = 1,
    localparam int CW      = (NWINDOWS <= 2) ? 1 : $clog2(NWINDOWS),
    localparam int NPHYS   = 8 + 16 * NWINDOWS
) (
    input  logic Clk,
    input  logic Rst_n,
    sparc_window_decoder_if.slave bus
);

    localparam logic [CW-1:0] LAST_WIN = CW'(NWINDOWS - 1);

    logic [NPHYS-1:0]    sel_q;
    logic                sel_valid_q;
    logic [CW-1:0]       cwp_q;
    logic [NWINDOWS-1:0] wim_q;
    logic                ovf_q;
    logic                unf_q;
    logic                ill_q;

    logic [CW-1:0]       cwp_dec;
    logic [CW-1:0]       cwp_inc;
    logic [CW-1:0]       cwp_next;
    logic                ovf_next;
    logic                unf_next;
    logic                ill_next;
    logic                cwp_in_ok;
    logic [NPHYS-1:0]    sel_next;
    int                  phys_idx;

    // Neighbouring windows with wrap-around; cwp_inc also locates the ins,
    // which alias the outs of the next window up.
    always_comb begin
        cwp_dec   = (cwp_q == '0) ? LAST_WIN : cwp_q - CW'(1);
        cwp_inc   = (cwp_q == LAST_WIN) ? '0 : cwp_q + CW'(1);
        cwp_in_ok = int'(bus.CwpIn) < NWINDOWS;
    end

    // Logical-to-physical mapping, always from the pre-edge window pointer.
    always_comb begin
        phys_idx = 0;
        sel_next = '0;
        if (bus.RegIn < 5'd8) begin
            phys_idx = int'(bus.RegIn);
        end else if (bus.RegIn < 5'd24) begin
            phys_idx = 16 * int'(cwp_q) + int'(bus.RegIn);
        end else begin
            phys_idx = 16 * int'(cwp_inc) + int'(bus.RegIn) - 16;
        end
        if (!(R0_ZERO != 0 && bus.RegIn == 5'd0)) begin
            sel_next = NPHYS'(1) << phys_idx;
        end
    end

    // Window pointer control: conflict, direct write, SAVE, RESTORE in that order.
    always_comb begin
        cwp_next = cwp_q;
        ovf_next = 1'b0;
        unf_next = 1'b0;
        ill_next = 1'b0;
        if (bus.Save && bus.Restore) begin
            ill_next = 1'b1;
        end else if (bus.WrCwp) begin
            if (cwp_in_ok) begin
                cwp_next = bus.CwpIn;
            end else begin
                ill_next = 1'b1;
            end
        end else if (bus.Save) begin
            if (wim_q[cwp_dec]) begin
                ovf_next = 1'b1;
            end else begin
                cwp_next = cwp_dec;
            end
        end else if (bus.Restore) begin
            if (wim_q[cwp_inc]) begin
                unf_next = 1'b1;
            end else begin
                cwp_next = cwp_inc;
            end
        end
    end

    // All state and pulse outputs register here; reset clears everything at once.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            cwp_q       <= '0;
            wim_q       <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            sel_q       <= bus.Ld ? sel_next : '0;
            sel_valid_q <= bus.Ld && (sel_next != '0);
            cwp_q       <= cwp_next;
            if (bus.LdWim) begin
                wim_q <= bus.WimIn;
            end
            ovf_q       <= ovf_next;
            unf_q       <= unf_next;
            ill_q       <= ill_next;
        end
    end

    assign bus.Sel       = sel_q;
    assign bus.SelValid  = sel_valid_q;
    assign bus.Cwp       = cwp_q;
    assign bus.Wim       = wim_q;
    assign bus.OvfTrap   = ovf_q;
    assign bus.UnfTrap   = unf_q;
    assign bus.IllegalOp = ill_q;

endmodule
